ds_operand_unit: RTL and testbench
==================================

DS_OPERAND_UNIT -- requirements
Module: ds_operand_unit

Interface
REQ-001 Parameter: CNT_W, 32, stall-counter width.
REQ-002 clk  input  1  single clock, all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 fs_to_ds_valid  input  1  fetch stage offers an instruction.
REQ-005 fs_raddr1 / fs_raddr2  input  5 each  source register numbers of offered instruction.
REQ-006 fs_use1 / fs_use2  input  1 each  source actually read by offered instruction.
REQ-007 ds_allow_in  output  1  this stage accepts an instruction this cycle.
REQ-008 es_allow_in  input  1  execute stage accepts.
REQ-009 ds_to_es_valid  output  1  operands valid toward execute.
REQ-010 ds_flush  input  1  branch taken/redirect, kill held instruction.
REQ-011 es_to_ds_bus  input  39  [31:0] result, [36:32] dest, [37] we (sender-valid-qualified), [38] is_load.
REQ-012 ms_to_ds_bus  input  38  [31:0] result, [36:32] dest, [37] we.
REQ-013 ws_to_ds_bus  input  38  [31:0] wdata, [36:32] waddr, [37] we; sole register-file write port.
REQ-014 rdata1 / rdata2  output  32 each  resolved operands.
REQ-015 stall_cnt  output  CNT_W  load-use stall cycles counted.

Function
REQ-016 ds_valid register: on ds_flush -> 0; else if ds_allow_in -> fs_to_ds_valid.
REQ-017 On ds_allow_in && fs_to_ds_valid, latch fs_raddr1/2, fs_use1/2 into held fields; otherwise hold.
REQ-018 Register file: 32x32, write at posedge when ws we=1 and waddr!=0; writes to r0 ignored; r0 always reads 0.
REQ-019 Per source: match_X = X.we && X.dest==held_raddr && held_raddr!=0 && held_use.
REQ-020 Operand priority ES > MS > WS > register file, purely combinational, zero-cycle latency.
REQ-021 WS write and read of same register in same cycle returns the new WS data (bypass), not stale RF.
REQ-022 load_use_stall = ds_valid && (match_ES on either source) && es is_load=1.
REQ-023 ds_ready_go = !load_use_stall; ds_allow_in = !ds_valid || (ds_ready_go && es_allow_in).
REQ-024 ds_to_es_valid = ds_valid && ds_ready_go && !ds_flush.
REQ-025 While stalled, held fields and ds_valid hold; operands re-resolve each cycle until MS supplies load data.
REQ-026 stall_cnt increments by 1 each cycle load_use_stall=1; saturates at all-ones, no wrap.
REQ-027 ds_flush concurrent with stall: flush wins, ds_valid -> 0, counter still counts that cycle.
REQ-028 Both sources matching different producers resolve independently.

Reset
REQ-029 reset=1 at posedge: ds_valid=0, held fields=0, stall_cnt=0, all 32 registers=0.
REQ-030 Outputs during/after reset: ds_allow_in=1, ds_to_es_valid=0, rdata1/2=0 (no producer matches).
REQ-031 Reset mid-stall discards held instruction; no RF write occurs on the reset edge.

Structure
REQ-032 Shared package cpu_bus_pkg: WIDTH_ES_TO_DS_BUS=39, WIDTH_MS_TO_DS_BUS=38, WIDTH_WS_TO_DS_BUS=38, bus field offsets.
REQ-033 One sub-module regfile_2r1w (32x32, two async read ports, one sync write port, r0 hardwired zero).
REQ-034 Forwarding mux, stall logic, handshake and counter live in ds_operand_unit.

Verification
REQ-035 WS writes r5=0x1234_5678; next cycle read r5 with no producers -> rdata1=0x1234_5678.
REQ-036 Same cycle: ES dest r3=0xA, MS dest r3=0xB, WS dest r3=0xC, read r3 -> rdata1=0xA; drop ES -> 0xB; drop MS -> 0xC.
REQ-037 ES is_load dest r7, held instr reads r7 -> ds_to_es_valid=0, ds_allow_in=0, stall_cnt 0->1; next cycle load in MS with 0x99 -> rdata=0x99, ds_to_es_valid=1.
REQ-038 WS we=1 waddr=0 wdata=0xFFFF_FFFF; read r0 -> 0; producer dest r0 never forwards.
REQ-039 Stall active, assert ds_flush -> next cycle ds_valid=0, ds_allow_in=1; stall_cnt preset near all-ones saturates, no wrap.
REQ-040 es_allow_in=0 with ds_valid=1, no hazard -> ds_allow_in=0, held raddr unchanged despite new fs_raddr.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg
//   Shared widths and field offsets for the stage-to-decode forwarding buses,
//   plus the unpacked producer view used by the operand forwarding logic.
//   es_to_ds_bus: [31:0] result, [36:32] dest, [37] we, [38] is_load
//   ms_to_ds_bus: [31:0] result, [36:32] dest, [37] we
//   ws_to_ds_bus: [31:0] wdata,  [36:32] waddr, [37] we
package cpu_bus_pkg;

    localparam int unsigned WIDTH_ES_TO_DS_BUS = 39;
    localparam int unsigned WIDTH_MS_TO_DS_BUS = 38;
    localparam int unsigned WIDTH_WS_TO_DS_BUS = 38;

    localparam int unsigned BUS_DATA_LSB = 0;
    localparam int unsigned BUS_DATA_MSB = 31;
    localparam int unsigned BUS_DEST_LSB = 32;
    localparam int unsigned BUS_DEST_MSB = 36;
    localparam int unsigned BUS_WE_BIT   = 37;
    localparam int unsigned BUS_LOAD_BIT = 38;

    typedef struct packed {
        logic        we;
        logic [4:0]  dest;
        logic [31:0] data;
    } fwd_src_t;

    // A producer forwards to a source only when that source is really read
    // and is not r0.
    function automatic logic fwd_hit(input fwd_src_t src,
                                     input logic [4:0] raddr,
                                     input logic use_src);
        return src.we && (src.dest == raddr) && (raddr != 5'd0) && use_src;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w
//   32x32 register file, two asynchronous read ports, one synchronous write
//   port. r0 reads as zero and ignores writes. Synchronous active-high reset
//   clears every register and blocks the write on the reset edge.
//   Ports: clk, reset, we/waddr/wdata (write), raddr1/rdata1, raddr2/rdata2.
module regfile_2r1w (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2
);

    logic [31:0] regs [32];

    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= '{default: '0};
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/ds_operand_unit.sv
// ds_operand_unit
//   Decode-stage operand unit: holds the instruction offered by fetch, reads
//   the register file, forwards results from ES/MS/WS (priority ES > MS > WS
//   > RF), detects load-use hazards against ES and counts stall cycles.
//   Ports: clk, reset; fs_to_ds_valid, fs_raddr1/2, fs_use1/2 (fetch offer);
//   ds_allow_in, es_allow_in, ds_to_es_valid, ds_flush (handshake);
//   es/ms/ws_to_ds_bus (producers, WS also writes the RF);
//   rdata1/2 (resolved operands); stall_cnt (saturating load-use stalls).
module ds_operand_unit
    import cpu_bus_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fs_to_ds_valid,
    input  logic [4:0]                    fs_raddr1,
    input  logic [4:0]                    fs_raddr2,
    input  logic                          fs_use1,
    input  logic                          fs_use2,
    output logic                          ds_allow_in,
    input  logic                          es_allow_in,
    output logic                          ds_to_es_valid,
    input  logic                          ds_flush,
    input  logic [WIDTH_ES_TO_DS_BUS-1:0] es_to_ds_bus,
    input  logic [WIDTH_MS_TO_DS_BUS-1:0] ms_to_ds_bus,
    input  logic [WIDTH_WS_TO_DS_BUS-1:0] ws_to_ds_bus,
    output logic [31:0]                   rdata1,
    output logic [31:0]                   rdata2,
    output logic [CNT_W-1:0]              stall_cnt
);

    logic        ds_valid;
    logic [4:0]  held_raddr1;
    logic [4:0]  held_raddr2;
    logic        held_use1;
    logic        held_use2;

    fwd_src_t    es_src;
    fwd_src_t    ms_src;
    fwd_src_t    ws_src;
    logic        es_is_load;

    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        load_use_stall;
    logic        ds_ready_go;

    assign es_src.we    = es_to_ds_bus[BUS_WE_BIT];
    assign es_src.dest  = es_to_ds_bus[BUS_DEST_MSB:BUS_DEST_LSB];
    assign es_src.data  = es_to_ds_bus[BUS_DATA_MSB:BUS_DATA_LSB];
    assign es_is_load   = es_to_ds_bus[BUS_LOAD_BIT];
    assign ms_src.we    = ms_to_ds_bus[BUS_WE_BIT];
    assign ms_src.dest  = ms_to_ds_bus[BUS_DEST_MSB:BUS_DEST_LSB];
    assign ms_src.data  = ms_to_ds_bus[BUS_DATA_MSB:BUS_DATA_LSB];
    assign ws_src.we    = ws_to_ds_bus[BUS_WE_BIT];
    assign ws_src.dest  = ws_to_ds_bus[BUS_DEST_MSB:BUS_DEST_LSB];
    assign ws_src.data  = ws_to_ds_bus[BUS_DATA_MSB:BUS_DATA_LSB];

    regfile_2r1w u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (ws_src.we),
        .waddr  (ws_src.dest),
        .wdata  (ws_src.data),
        .raddr1 (held_raddr1),
        .rdata1 (rf_rdata1),
        .raddr2 (held_raddr2),
        .rdata2 (rf_rdata2)
    );

    // Later assignments win, so the youngest producer (ES) is written last.
    // The WS term also covers the same-cycle write/read of the register file.
    always_comb begin
        rdata1 = rf_rdata1;
        if (fwd_hit(ws_src, held_raddr1, held_use1)) rdata1 = ws_src.data;
        if (fwd_hit(ms_src, held_raddr1, held_use1)) rdata1 = ms_src.data;
        if (fwd_hit(es_src, held_raddr1, held_use1)) rdata1 = es_src.data;

        rdata2 = rf_rdata2;
        if (fwd_hit(ws_src, held_raddr2, held_use2)) rdata2 = ws_src.data;
        if (fwd_hit(ms_src, held_raddr2, held_use2)) rdata2 = ms_src.data;
        if (fwd_hit(es_src, held_raddr2, held_use2)) rdata2 = es_src.data;
    end

    // A load in ES has no data yet; wait until it reaches MS.
    assign load_use_stall = ds_valid && es_is_load &&
                            (fwd_hit(es_src, held_raddr1, held_use1) ||
                             fwd_hit(es_src, held_raddr2, held_use2));
    assign ds_ready_go    = !load_use_stall;
    assign ds_allow_in    = !ds_valid || (ds_ready_go && es_allow_in);
    assign ds_to_es_valid = ds_valid && ds_ready_go && !ds_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            ds_valid    <= 1'b0;
            held_raddr1 <= '0;
            held_raddr2 <= '0;
            held_use1   <= 1'b0;
            held_use2   <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            if (ds_flush) begin
                ds_valid <= 1'b0;
            end else if (ds_allow_in) begin
                ds_valid <= fs_to_ds_valid;
            end

            if (ds_allow_in && fs_to_ds_valid) begin
                held_raddr1 <= fs_raddr1;
                held_raddr2 <= fs_raddr2;
                held_use1   <= fs_use1;
                held_use2   <= fs_use2;
            end

            if (load_use_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ds_operand_unit.sv
module tb_ds_operand_unit;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             fs_to_ds_valid;
    logic [4:0]       fs_raddr1, fs_raddr2;
    logic             fs_use1, fs_use2;
    logic             ds_allow_in;
    logic             es_allow_in;
    logic             ds_to_es_valid;
    logic             ds_flush;
    logic [38:0]      es_to_ds_bus;
    logic [37:0]      ms_to_ds_bus;
    logic [37:0]      ws_to_ds_bus;
    logic [31:0]      rdata1, rdata2;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    ds_operand_unit #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_raddr1      (fs_raddr1),
        .fs_raddr2      (fs_raddr2),
        .fs_use1        (fs_use1),
        .fs_use2        (fs_use2),
        .ds_allow_in    (ds_allow_in),
        .es_allow_in    (es_allow_in),
        .ds_to_es_valid (ds_to_es_valid),
        .ds_flush       (ds_flush),
        .es_to_ds_bus   (es_to_ds_bus),
        .ms_to_ds_bus   (ms_to_ds_bus),
        .ws_to_ds_bus   (ws_to_ds_bus),
        .rdata1         (rdata1),
        .rdata2         (rdata2),
        .stall_cnt      (stall_cnt)
    );

    // Reference model state: architectural registers plus the held instruction.
    logic [31:0] m_rf [32];
    logic        m_valid;
    logic [4:0]  m_r1, m_r2;
    logic        m_u1, m_u2;
    int unsigned m_cnt;

    int vectors    = 0;
    int miscompares = 0;

    function automatic logic [38:0] es_bus(input logic ld, input logic we,
                                           input logic [4:0] d, input logic [31:0] v);
        return {ld, we, d, v};
    endfunction

    function automatic logic [37:0] mw_bus(input logic we, input logic [4:0] d,
                                           input logic [31:0] v);
        return {we, d, v};
    endfunction

    function automatic logic [31:0] m_operand(input logic [4:0] ra, input logic u);
        if (u && ra != 0 && es_to_ds_bus[37] && es_to_ds_bus[36:32] == ra) return es_to_ds_bus[31:0];
        if (u && ra != 0 && ms_to_ds_bus[37] && ms_to_ds_bus[36:32] == ra) return ms_to_ds_bus[31:0];
        if (u && ra != 0 && ws_to_ds_bus[37] && ws_to_ds_bus[36:32] == ra) return ws_to_ds_bus[31:0];
        return (ra == 0) ? 32'd0 : m_rf[ra];
    endfunction

    function automatic logic m_stall();
        logic w1, w2;
        w1 = m_u1 && m_r1 != 0 && es_to_ds_bus[36:32] == m_r1;
        w2 = m_u2 && m_r2 != 0 && es_to_ds_bus[36:32] == m_r2;
        return m_valid && es_to_ds_bus[38] && es_to_ds_bus[37] && (w1 || w2);
    endfunction

    function automatic logic m_allow();
        return !m_valid || (!m_stall() && es_allow_in);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_valid = 1'b0;
        m_r1 = '0; m_r2 = '0; m_u1 = 1'b0; m_u2 = 1'b0;
        m_cnt = 0;
    endtask

    // Compare all meaningful outputs against the model for the current inputs.
    task automatic apply();
        #2;
        check("ds_allow_in", 32'(ds_allow_in), 32'(m_allow()));
        check("ds_to_es_valid", 32'(ds_to_es_valid), 32'(m_valid && !m_stall() && !ds_flush));
        check("stall_cnt", 32'(stall_cnt), m_cnt);
        if (m_u1) check("rdata1", rdata1, m_operand(m_r1, 1'b1));
        if (m_u2) check("rdata2", rdata2, m_operand(m_r2, 1'b1));
    endtask

    // Advance the model by one clock with the current inputs, then the DUT.
    task automatic tick();
        logic st, al;
        if (reset) begin
            model_reset();
        end else begin
            st = m_stall();
            al = m_allow();
            if (ws_to_ds_bus[37] && ws_to_ds_bus[36:32] != 0) m_rf[ws_to_ds_bus[36:32]] = ws_to_ds_bus[31:0];
            if (st && m_cnt < CNT_MAX) m_cnt++;
            if (al && fs_to_ds_valid) begin
                m_r1 = fs_raddr1; m_r2 = fs_raddr2; m_u1 = fs_use1; m_u2 = fs_use2;
            end
            if (ds_flush) m_valid = 1'b0;
            else if (al) m_valid = fs_to_ds_valid;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        reset = 1'b0;
        fs_to_ds_valid = 1'b0;
        fs_raddr1 = '0; fs_raddr2 = '0;
        fs_use1 = 1'b0; fs_use2 = 1'b0;
        es_allow_in = 1'b1;
        ds_flush = 1'b0;
        es_to_ds_bus = '0;
        ms_to_ds_bus = '0;
        ws_to_ds_bus = '0;
    endtask

    task automatic offer(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
        fs_to_ds_valid = 1'b1;
        fs_raddr1 = r1; fs_use1 = u1;
        fs_raddr2 = r2; fs_use2 = u2;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        apply();
        tick();
        reset = 1'b0;

        // Reset state
        apply();
        check("rst_allow", 32'(ds_allow_in), 32'd1);
        check("rst_to_es", 32'(ds_to_es_valid), 32'd0);
        check("rst_rdata1", rdata1, 32'd0);
        check("rst_cnt", 32'(stall_cnt), 32'd0);
        tick();

        // WS write then read through the register file
        ws_to_ds_bus = mw_bus(1'b1, 5'd5, 32'h1234_5678);
        apply(); tick();
        ws_to_ds_bus = '0;
        offer(5'd5, 1'b1, 5'd0, 1'b0);
        apply(); tick();
        fs_to_ds_valid = 1'b0;
        apply();
        check("rf_read_r5", rdata1, 32'h1234_5678);
        check("rf_read_valid", 32'(ds_to_es_valid), 32'd1);
        tick();

        // Forwarding priority ES > MS > WS
        offer(5'd3, 1'b1, 5'd0, 1'b0);
        apply(); tick();
        fs_to_ds_valid = 1'b0;
        es_to_ds_bus = es_bus(1'b0, 1'b1, 5'd3, 32'hA);
        ms_to_ds_bus = mw_bus(1'b1, 5'd3, 32'hB);
        ws_to_ds_bus = mw_bus(1'b1, 5'd3, 32'hC);
        apply();
        check("prio_es", rdata1, 32'hA);
        es_to_ds_bus = '0;
        apply();
        check("prio_ms", rdata1, 32'hB);
        ms_to_ds_bus = '0;
        apply();
        check("prio_ws", rdata1, 32'hC);
        tick();
        ws_to_ds_bus = '0;

        // Load-use stall, resolved once the load reaches MS
        offer(5'd7, 1'b1, 5'd0, 1'b0);
        apply(); tick();
        fs_to_ds_valid = 1'b0;
        es_to_ds_bus = es_bus(1'b1, 1'b1, 5'd7, 32'h5);
        apply();
        check("lu_to_es", 32'(ds_to_es_valid), 32'd0);
        check("lu_allow", 32'(ds_allow_in), 32'd0);
        check("lu_cnt0", 32'(stall_cnt), 32'd0);
        tick();
        es_to_ds_bus = '0;
        ms_to_ds_bus = mw_bus(1'b1, 5'd7, 32'h99);
        apply();
        check("lu_data", rdata1, 32'h99);
        check("lu_released", 32'(ds_to_es_valid), 32'd1);
        check("lu_cnt1", 32'(stall_cnt), 32'd1);
        tick();
        ms_to_ds_bus = '0;

        // r0 is never written and never forwarded
        ws_to_ds_bus = mw_bus(1'b1, 5'd0, 32'hFFFF_FFFF);
        es_to_ds_bus = es_bus(1'b0, 1'b1, 5'd0, 32'h55);
        ms_to_ds_bus = mw_bus(1'b1, 5'd0, 32'h66);
        offer(5'd0, 1'b1, 5'd0, 1'b1);
        apply(); tick();
        fs_to_ds_valid = 1'b0;
        ws_to_ds_bus = '0;
        apply();
        check("r0_rdata1", rdata1, 32'd0);
        check("r0_rdata2", rdata2, 32'd0);
        tick();
        es_to_ds_bus = '0; ms_to_ds_bus = '0;

        // Independent sources from different producers
        offer(5'd10, 1'b1, 5'd11, 1'b1);
        apply(); tick();
        fs_to_ds_valid = 1'b0;
        es_to_ds_bus = es_bus(1'b0, 1'b1, 5'd10, 32'hE0);
        ms_to_ds_bus = mw_bus(1'b1, 5'd11, 32'hF1);
        apply();
        check("dual_rdata1", rdata1, 32'hE0);
        check("dual_rdata2", rdata2, 32'hF1);
        tick();
        es_to_ds_bus = '0; ms_to_ds_bus = '0;

        // Counter saturation, then flush during stall
        offer(5'd9, 1'b1, 5'd0, 1'b0);
        apply(); tick();
        fs_to_ds_valid = 1'b0;
        es_to_ds_bus = es_bus(1'b1, 1'b1, 5'd9, 32'h0);
        for (int i = 0; i < 16; i++) begin
            apply(); tick();
        end
        ds_flush = 1'b1;
        apply();
        check("sat_cnt", 32'(stall_cnt), 32'hF);
        check("flush_to_es", 32'(ds_to_es_valid), 32'd0);
        tick();
        ds_flush = 1'b0;
        apply();
        check("flush_allow", 32'(ds_allow_in), 32'd1);
        check("flush_cnt", 32'(stall_cnt), 32'hF);
        tick();
        es_to_ds_bus = '0;

        // Back-pressure from ES holds the instruction
        offer(5'd4, 1'b1, 5'd0, 1'b0);
        apply(); tick();
        offer(5'd6, 1'b1, 5'd0, 1'b0);
        es_allow_in = 1'b0;
        ws_to_ds_bus = mw_bus(1'b1, 5'd4, 32'h44);
        apply();
        check("bp_allow", 32'(ds_allow_in), 32'd0);
        tick();
        fs_to_ds_valid = 1'b0;
        es_allow_in = 1'b1;
        ws_to_ds_bus = '0;
        apply();
        check("bp_held", rdata1, 32'h44);
        tick();

        // Randomized traffic over a narrow register range to force hazards
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            fs_to_ds_valid = 1'($urandom_range(0, 1));
            fs_raddr1 = 5'($urandom_range(0, 7));
            fs_raddr2 = 5'($urandom_range(0, 7));
            fs_use1 = ($urandom_range(0, 3) != 0);
            fs_use2 = ($urandom_range(0, 3) != 0);
            es_allow_in = ($urandom_range(0, 3) != 0);
            ds_flush = ($urandom_range(0, 9) == 0);
            es_to_ds_bus = es_bus(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                                  5'($urandom_range(0, 7)), $urandom);
            ms_to_ds_bus = mw_bus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            ws_to_ds_bus = mw_bus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            apply();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
